hazard_flush_ctrl: RTL and testbench

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

---
 rtl/mznm_pkg.sv | 34 +++
 rtl/load_use_detect.sv | 21 ++
 rtl/hazard_flush_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mznm_pkg.sv
// Shared opcode constants, PC-select encodings and hazard/flush FSM state encoding.
package mznm_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_POP  = 5'h0C;
  localparam logic [4:0] OP_LDD  = 5'h14;
  localparam logic [4:0] OP_JMP  = 5'h1B;
  localparam logic [4:0] OP_CALL = 5'h1C;
  localparam logic [4:0] OP_RET  = 5'h1D;
  localparam logic [4:0] OP_RTI  = 5'h1E;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BRT = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;
  localparam logic [1:0] PC_INT = 2'b11;

  localparam logic [2:0] FLASH_INIT = 3'd2;

  typedef enum logic [1:0] {
    S_RUN       = 2'b00,
    S_LOADSTALL = 2'b01,
    S_RETWAIT   = 2'b10,
    S_FLUSH     = 2'b11
  } state_e;

  function automatic logic is_ret_op(input logic [4:0] opcode);
    return (opcode == OP_RET) || (opcode == OP_RTI);
  endfunction

  function automatic logic is_load_op(input logic [4:0] opcode);
    return (opcode == OP_LDD) || (opcode == OP_POP);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the decode sources and the execute load target.
module load_use_detect
  import mznm_pkg::*;
(
  input  logic [4:0] e_opcode,
  input  logic [2:0] e_dst,
  input  logic [2:0] d_src1,
  input  logic [2:0] d_src2,
  input  logic       d_use1,
  input  logic       d_use2,
  output logic       hazard
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = d_use1 && (d_src1 == e_dst);
  assign src2_hit = d_use2 && (d_src2 == e_dst);
  assign hazard   = is_load_op(e_opcode) && (src1_hit || src2_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard and flush controller: load-use stalls, taken-branch/interrupt flushes and
// return-address waits, with a registered drain counter for the decode/execute buffer.
module hazard_flush_ctrl
  import mznm_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] DOpcode,
  input  logic [2:0] DSrc1,
  input  logic [2:0] DSrc2,
  input  logic       DUse1,
  input  logic       DUse2,
  input  logic [4:0] EOpcode,
  input  logic [2:0] EDst,
  input  logic       ETaken,
  input  logic       MRetValid,
  input  logic       IntReq,
  output logic       StallFD,
  output logic       PCHold,
  output logic       BubbleDE,
  output logic       FlushFD,
  output logic       FlushDE,
  output logic       IntAck,
  output logic       Busy,
  output logic [1:0] PCSel,
  output logic [2:0] FlashNum
);

  state_e     state_q, state_d;
  logic [2:0] flash_num_q, flash_num_d;
  logic       load_use;

  logic       stall_fd, pc_hold, bubble_de, flush_fd, flush_de, int_ack, busy;
  logic [1:0] pc_sel;

  // Decode opcode is not needed: DUse1/DUse2 already qualify the source reads.
  logic unused_dopcode;
  assign unused_dopcode = ^DOpcode;

  load_use_detect u_load_use_detect (
    .e_opcode (EOpcode),
    .e_dst    (EDst),
    .d_src1   (DSrc1),
    .d_src2   (DSrc2),
    .d_use1   (DUse1),
    .d_use2   (DUse2),
    .hazard   (load_use)
  );

  always_comb begin
    state_d     = state_q;
    flash_num_d = flash_num_q;
    stall_fd    = 1'b0;
    pc_hold     = 1'b0;
    bubble_de   = 1'b0;
    flush_fd    = 1'b0;
    flush_de    = 1'b0;
    int_ack     = 1'b0;
    busy        = 1'b0;
    pc_sel      = PC_SEQ;
    unique case (state_q)
      S_RUN: begin
        flash_num_d = '0;
        if (is_ret_op(EOpcode)) begin
          flush_fd    = 1'b1;
          flush_de    = 1'b1;
          pc_hold     = 1'b1;
          state_d     = S_RETWAIT;
          flash_num_d = FLASH_INIT;
        end else if (ETaken) begin
          pc_sel      = PC_BRT;
          flush_fd    = 1'b1;
          flush_de    = 1'b1;
          state_d     = S_FLUSH;
          flash_num_d = FLASH_INIT;
        end else if (IntReq) begin
          int_ack     = 1'b1;
          pc_sel      = PC_INT;
          flush_fd    = 1'b1;
          flush_de    = 1'b1;
          state_d     = S_FLUSH;
          flash_num_d = FLASH_INIT;
        end else if (load_use) begin
          stall_fd  = 1'b1;
          pc_hold   = 1'b1;
          bubble_de = 1'b1;
          state_d   = S_LOADSTALL;
        end
      end
      S_LOADSTALL: begin
        busy        = 1'b1;
        state_d     = S_RUN;
        flash_num_d = '0;
      end
      S_RETWAIT: begin
        busy = 1'b1;
        if (MRetValid) begin
          pc_sel      = PC_RET;
          state_d     = S_RUN;
          flash_num_d = '0;
        end else begin
          flush_fd    = 1'b1;
          pc_hold     = 1'b1;
          flash_num_d = (flash_num_q == 3'd0) ? 3'd0 : flash_num_q - 3'd1;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        // Leave on the last drain cycle; <= also recovers from a zero count.
        if (flash_num_q <= 3'd1) begin
          state_d     = S_RUN;
          flash_num_d = '0;
        end else begin
          flash_num_d = flash_num_q - 3'd1;
        end
      end
      default: begin
        state_d     = S_RUN;
        flash_num_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_RUN;
      flash_num_q <= '0;
    end else begin
      state_q     <= state_d;
      flash_num_q <= flash_num_d;
    end
  end

  assign StallFD  = ~Rst & stall_fd;
  assign PCHold   = ~Rst & pc_hold;
  assign BubbleDE = ~Rst & bubble_de;
  assign FlushFD  = ~Rst & flush_fd;
  assign FlushDE  = ~Rst & flush_de;
  assign IntAck   = ~Rst & int_ack;
  assign Busy     = ~Rst & busy;
  assign PCSel    = Rst ? PC_SEQ : pc_sel;
  assign FlashNum = Rst ? 3'd0 : flash_num_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Table-driven check of hazard_flush_ctrl plus a hand-written long return-wait sequence.
module tb_hazard_flush_ctrl;
  import mznm_pkg::*;

  logic       Clk;
  logic       Rst;
  logic [4:0] DOpcode;
  logic [2:0] DSrc1, DSrc2;
  logic       DUse1, DUse2;
  logic [4:0] EOpcode;
  logic [2:0] EDst;
  logic       ETaken, MRetValid, IntReq;
  logic       StallFD, PCHold, BubbleDE, FlushFD, FlushDE, IntAck, Busy;
  logic [1:0] PCSel;
  logic [2:0] FlashNum;

  int nvec  = 0;
  int nfail = 0;

  hazard_flush_ctrl dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .DOpcode   (DOpcode),
    .DSrc1     (DSrc1),
    .DSrc2     (DSrc2),
    .DUse1     (DUse1),
    .DUse2     (DUse2),
    .EOpcode   (EOpcode),
    .EDst      (EDst),
    .ETaken    (ETaken),
    .MRetValid (MRetValid),
    .IntReq    (IntReq),
    .StallFD   (StallFD),
    .PCHold    (PCHold),
    .BubbleDE  (BubbleDE),
    .FlushFD   (FlushFD),
    .FlushDE   (FlushDE),
    .IntAck    (IntAck),
    .Busy      (Busy),
    .PCSel     (PCSel),
    .FlashNum  (FlashNum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ctl bit order: {StallFD, PCHold, BubbleDE, FlushFD, FlushDE, IntAck, Busy}
  typedef struct {
    logic       rst;
    logic [4:0] eop;
    logic [2:0] edst;
    logic       et;
    logic       mr;
    logic       ir;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [6:0] ctl;
    logic [1:0] pcs;
    logic [2:0] fn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [4:0] eop, input logic [2:0] edst,
                     input logic et, input logic mr, input logic ir,
                     input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2,
                     input logic [6:0] ctl, input logic [1:0] pcs, input logic [2:0] fn);
    vec_t v;
    v.rst = r; v.eop = eop; v.edst = edst; v.et = et; v.mr = mr; v.ir = ir;
    v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.ctl = ctl; v.pcs = pcs; v.fn = fn;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    Rst = v.rst; EOpcode = v.eop; EDst = v.edst; ETaken = v.et; MRetValid = v.mr;
    IntReq = v.ir; DSrc1 = v.s1; DUse1 = v.u1; DSrc2 = v.s2; DUse2 = v.u2;
    DOpcode = OP_NOP;
  endtask

  task automatic check(input string name, input logic [6:0] ctl, input logic [1:0] pcs,
                       input logic [2:0] fn);
    logic [6:0] act_ctl;
    act_ctl = {StallFD, PCHold, BubbleDE, FlushFD, FlushDE, IntAck, Busy};
    nvec++;
    if (act_ctl !== ctl || PCSel !== pcs || FlashNum !== fn) begin
      nfail++;
      $display("FAIL %s: got ctl=%b pcsel=%b flashnum=%0d, expected ctl=%b pcsel=%b flashnum=%0d",
               name, act_ctl, PCSel, FlashNum, ctl, pcs, fn);
    end
  endtask

  // Drive, sample mid-cycle, then advance one clock.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #3;
    check(name, v.ctl, v.pcs, v.fn);
    @(posedge Clk);
    #1;
  endtask

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1110000;
  localparam logic [6:0] C_BUSY  = 7'b0000001;
  localparam logic [6:0] C_BR    = 7'b0001100;
  localparam logic [6:0] C_INT   = 7'b0001110;
  localparam logic [6:0] C_RET   = 7'b0101100;
  localparam logic [6:0] C_RWAIT = 7'b0101001;

  initial begin
    vec_t v;
    int fn_exp[6] = '{2, 1, 0, 0, 0, 0};

    //  rst eop     edst et mr ir s1 u1 s2 u2  ctl      pcs     fn
    // reset overrides a branch request
    add(1, OP_NOP, 0, 1, 0, 1, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // load-use via src1, load-stall ignores events, then idle
    add(0, OP_LDD, 3, 0, 0, 0, 3, 1, 0, 0, C_STALL, PC_SEQ, 0);
    add(0, OP_NOP, 0, 1, 0, 1, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // same with DUse1=0: no stall
    add(0, OP_LDD, 3, 0, 0, 0, 3, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // load-use via src2, then POP via src1
    add(0, OP_LDD, 5, 0, 0, 0, 0, 0, 5, 1, C_STALL, PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 0);
    add(0, OP_POP, 2, 0, 0, 0, 2, 1, 0, 0, C_STALL, PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 0);
    add(0, OP_POP, 2, 0, 0, 0, 3, 1, 2, 0, C_IDLE,  PC_SEQ, 0);
    // taken branch: flush drains 2 cycles ignoring IntReq and hazards
    add(0, OP_NOP, 0, 1, 0, 0, 0, 0, 0, 0, C_BR,    PC_BRT, 0);
    add(0, OP_LDD, 1, 0, 0, 1, 1, 1, 0, 0, C_BUSY,  PC_SEQ, 2);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 1);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // RET, return address arrives on the 4th wait cycle
    add(0, OP_RET, 0, 0, 0, 0, 0, 0, 0, 0, C_RET,   PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_RWAIT, PC_SEQ, 2);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_RWAIT, PC_SEQ, 1);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_RWAIT, PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, C_BUSY,  PC_RET, 0);
    add(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // branch beats interrupt; held IntReq acks once after the flush
    add(0, OP_NOP, 0, 1, 0, 1, 0, 0, 0, 0, C_BR,    PC_BRT, 0);
    add(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 2);
    add(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 1);
    add(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, C_INT,   PC_INT, 0);
    add(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 2);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 1);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // RTI beats branch and interrupt; early return address
    add(0, OP_RTI, 0, 1, 0, 1, 0, 0, 0, 0, C_RET,   PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, C_RWAIT, PC_SEQ, 2);
    add(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, C_BUSY,  PC_RET, 1);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // interrupt beats load-use
    add(0, OP_LDD, 1, 0, 0, 1, 1, 1, 0, 0, C_INT,   PC_INT, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 2);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY,  PC_SEQ, 1);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // reset mid return-wait; later MRetValid ignored
    add(0, OP_RET, 0, 0, 0, 0, 0, 0, 0, 0, C_RET,   PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_RWAIT, PC_SEQ, 2);
    add(1, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    // reset mid flush
    add(0, OP_NOP, 0, 1, 0, 0, 0, 0, 0, 0, C_BR,    PC_BRT, 0);
    add(1, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);
    add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  PC_SEQ, 0);

    drive(vecs[0]);
    @(posedge Clk);
    #1;
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Long return wait: FlashNum saturates at 0 while FlushFD/PCHold stay held.
    v = vecs[1];
    v.eop = OP_RET; v.ctl = C_RET; v.pcs = PC_SEQ; v.fn = 3'd0;
    step(v, "ret_start");
    for (int k = 0; k < 6; k++) begin
      v = vecs[1];
      v.ctl = C_RWAIT; v.fn = 3'(fn_exp[k]);
      step(v, $sformatf("ret_wait%0d", k));
    end
    v = vecs[1];
    v.mr = 1'b1; v.ctl = C_BUSY; v.pcs = PC_RET; v.fn = 3'd0;
    step(v, "ret_done");
    v = vecs[1];
    step(v, "ret_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
